alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised multi-cycle ALU, the successor to the single-cycle datapath ALU. It adds registered results, an internal NZCV flags register, and carry-in ops (ADC/SBC). It also adds variable-count shifts (logical and arithmetic) and an iterative shift-add multiplier with a full-width product. It sits between the register file read ports and the writeback mux. The CPU sequencer drives it with a start/busy/done handshake.

Parameters:
DWIDTH, 16, data width in bits (>= 4)
SWIDTH, 4, shift-count width; equals log2(DWIDTH)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
op  input  4  operation code, sampled with start
adata  input  DWIDTH  operand A, sampled with start
bdata  input  DWIDTH  operand B, sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
rdata  output  DWIDTH  registered result (low half for MUL)
rdata_hi  output  DWIDTH  registered MUL high half; 0 for every other op
flags_o  output  4  flags register {N,Z,C,V}
flags_we  input  1  load flags register from flags_wdata (idle only)
flags_wdata  input  4  flags load value

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: busy=0, done=0, rdata=0, rdata_hi=0, flags_o=0, FSM=IDLE. Reset mid-operation aborts the operation: no done pulse and no flags or result update.
- FSM states: IDLE and RUN.
  - IDLE: on start, capture op/a/b and the current C flag.
  - Single-cycle op: complete at the same edge and stay in IDLE.
  - Shift with count > 0, or MUL: go to RUN.
  - RUN: one iteration per clock; on the last iteration, complete and go to IDLE.
- Timing: start sampled at edge E0. Completion writes rdata/rdata_hi/flags and sets done at edge E0+K, so done is high in the cycle after that edge for exactly one cycle.
  - K=0 for single-cycle ops.
  - K=n for shifts by n (n = bdata[SWIDTH-1:0]); n=0 is a single-cycle op.
  - K=DWIDTH for MUL.
  - busy is high for exactly K cycles. start while busy is ignored (not queued).
- Back-to-back: start may be asserted in the same cycle done is high.
- rdata and rdata_hi hold their value until the next completion.
- Op map (C, V unchanged unless stated):
  - 0 MOV: r=b; no flags change.
  - 1 AND, 2 OR, 3 XOR: update N,Z.
  - 4 ADD: r=a+b. C = carry out of bit DWIDTH-1. V = signed overflow.
  - 5 SUB: r=a-b. C = borrow (1 when a<b unsigned). V = signed overflow.
  - 6 ADC: r=a+b+Cin. 7 SBC: r=a-b-Cin. Cin is the C flag at E0; flag rules as for ADD/SUB.
  - 8 SHL, 9 SHR (logical), 10 ASR (sign-fill): shift a by n. Update N,Z. C = last bit shifted out when n>0; C unchanged when n=0.
  - 11 MUL: unsigned a*b, 2*DWIDTH-bit product {rdata_hi,rdata}. N,Z from the low half only.
  - 12 BIS: a | (1<<b[SWIDTH-1:0]). 13 BIC: a & ~bit. 14 TBS: a & bit. All three update N,Z.
  - 15 reserved: r=a; no flags change.
- N = r[DWIDTH-1]; Z = (r==0).
- rdata_hi is 0 on every non-MUL completion.
- flags_we:
  - Honoured only when busy=0; ignored while busy.
  - If flags_we and a single-cycle completion occur on the same edge, flags_we wins for all four flags.
  - ADC/SBC started on that same edge still use the pre-load C.

Test Plan:
- ADD 0x7FFF+0x0001 -> rdata=0x8000, flags=1001 (N,V set), done in cycle after start, busy never high.
- SUB 0x0003-0x0005 -> 0xFFFE, flags=1010. Then SBC 0x0010-0x0001 with C=1 -> 0x000E, flags=0000.
- MUL 0x1234*0x0100 -> rdata=0x3400, rdata_hi=0x0012, flags=0000.
  - busy high 16 cycles; done 17 cycles after start.
  - A start with ADD pulsed mid-MUL is ignored (no extra done).
- ASR 0x8001 by 3 -> 0xF000, N=1, C=0, done 4 cycles after start. SHL 0x8000 by 1 -> 0x0000, Z=1, C=1, done 2 cycles after start.
- Reset asserted at cycle 5 of a MUL -> busy=0, done=0, flags=0, rdata=0 next cycle; no done ever follows.
- flags_we with 0xF, then MOV 0x1234 -> rdata=0x1234, flags stay 1111. flags_we=1 with 0x0 during a MUL -> flags unchanged until completion writes them.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU with registered results, an NZCV flags register, iterative
// shifts and a shift-add multiplier, driven by a start/busy/done handshake.
module alu_seq #(
    parameter int DWIDTH = 16,
    parameter int SWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DWIDTH-1:0] adata,
    input  logic [DWIDTH-1:0] bdata,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] rdata,
    output logic [DWIDTH-1:0] rdata_hi,
    output logic [3:0]        flags_o,
    input  logic              flags_we,
    input  logic [3:0]        flags_wdata
);

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,  OP_AND = 4'd1,  OP_OR  = 4'd2,  OP_XOR = 4'd3,
        OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_ADC = 4'd6,  OP_SBC = 4'd7,
        OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ASR = 4'd10, OP_MUL = 4'd11,
        OP_BIS = 4'd12, OP_BIC = 4'd13, OP_TBS = 4'd14, OP_RSV = 4'd15
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [SWIDTH:0] CNT_ONE = {{SWIDTH{1'b0}}, 1'b1};

    state_e            state_q;
    op_e               op_q;
    logic              busy_q, done_q;
    logic [DWIDTH-1:0] rdata_q, rdata_hi_q;
    logic [3:0]        flags_q;           // {N,Z,C,V}
    logic [DWIDTH-1:0] work_q;            // shift operand, or MUL low half / multiplier
    logic [DWIDTH-1:0] mcand_q, hi_q;
    logic [SWIDTH:0]   cnt_q;

    op_e               cur_op;
    logic [SWIDTH-1:0] shamt;
    logic [DWIDTH-1:0] bmask, sc_res;
    logic [DWIDTH:0]   sum;
    logic [3:0]        sc_flags;
    logic              cin_use, upd_nz, multi_d;

    assign cur_op = op_e'(op);
    assign shamt  = bdata[SWIDTH-1:0];
    assign bmask  = {{(DWIDTH-1){1'b0}}, 1'b1} << shamt;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sc_res   = adata;
        sc_flags = flags_q;
        sum      = '0;
        cin_use  = 1'b0;
        upd_nz   = 1'b0;
        multi_d  = 1'b0;
        case (cur_op)
            OP_MOV: sc_res = bdata;
            OP_AND: begin sc_res = adata & bdata; upd_nz = 1'b1; end
            OP_OR:  begin sc_res = adata | bdata; upd_nz = 1'b1; end
            OP_XOR: begin sc_res = adata ^ bdata; upd_nz = 1'b1; end
            OP_ADD, OP_ADC: begin
                cin_use     = (cur_op == OP_ADC) & flags_q[1];
                sum         = {1'b0, adata} + {1'b0, bdata} + {{DWIDTH{1'b0}}, cin_use};
                sc_res      = sum[DWIDTH-1:0];
                sc_flags[1] = sum[DWIDTH];
                sc_flags[0] = (adata[DWIDTH-1] == bdata[DWIDTH-1]) &&
                              (sc_res[DWIDTH-1] != adata[DWIDTH-1]);
                upd_nz      = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                // The top bit of the widened difference is the borrow.
                cin_use     = (cur_op == OP_SBC) & flags_q[1];
                sum         = {1'b0, adata} - {1'b0, bdata} - {{DWIDTH{1'b0}}, cin_use};
                sc_res      = sum[DWIDTH-1:0];
                sc_flags[1] = sum[DWIDTH];
                sc_flags[0] = (adata[DWIDTH-1] != bdata[DWIDTH-1]) &&
                              (sc_res[DWIDTH-1] != adata[DWIDTH-1]);
                upd_nz      = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ASR: begin
                multi_d = (shamt != '0);
                upd_nz  = 1'b1;
            end
            OP_MUL: multi_d = 1'b1;
            OP_BIS: begin sc_res = adata | bmask;  upd_nz = 1'b1; end
            OP_BIC: begin sc_res = adata & ~bmask; upd_nz = 1'b1; end
            OP_TBS: begin sc_res = adata & bmask;  upd_nz = 1'b1; end
            default: sc_res = adata;
        endcase
        if (upd_nz) sc_flags[3:2] = {sc_res[DWIDTH-1], sc_res == '0};
    end

    // One iteration of the running shift or multiply.
    logic [DWIDTH-1:0] sh_next, hi_next, lo_next;
    logic              sh_out;
    logic [DWIDTH:0]   add_sum;

    always_comb begin
        case (op_q)
            OP_SHL:  begin sh_next = {work_q[DWIDTH-2:0], 1'b0};  sh_out = work_q[DWIDTH-1]; end
            OP_SHR:  begin sh_next = {1'b0, work_q[DWIDTH-1:1]};  sh_out = work_q[0]; end
            default: begin sh_next = {work_q[DWIDTH-1], work_q[DWIDTH-1:1]}; sh_out = work_q[0]; end
        endcase
        add_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : {(DWIDTH+1){1'b0}});
        hi_next = add_sum[DWIDTH:1];
        lo_next = {add_sum[0], work_q[DWIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MOV;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            rdata_hi_q <= '0;
            flags_q    <= '0;
            work_q     <= '0;
            mcand_q    <= '0;
            hi_q       <= '0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flags_we) flags_q <= flags_wdata;
                    if (start) begin
                        op_q <= cur_op;
                        if (!multi_d) begin
                            rdata_q    <= sc_res;
                            rdata_hi_q <= '0;
                            done_q     <= 1'b1;
                            if (!flags_we) flags_q <= sc_flags;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= (cur_op == OP_MUL) ? (SWIDTH+1)'(DWIDTH) : {1'b0, shamt};
                            work_q  <= (cur_op == OP_MUL) ? bdata : adata;
                            mcand_q <= adata;
                            hi_q    <= '0;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (op_q == OP_MUL) begin
                        hi_q   <= hi_next;
                        work_q <= lo_next;
                    end else begin
                        work_q <= sh_next;
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (op_q == OP_MUL) begin
                            rdata_q       <= lo_next;
                            rdata_hi_q    <= hi_next;
                            flags_q[3:2]  <= {lo_next[DWIDTH-1], lo_next == '0};
                        end else begin
                            rdata_q      <= sh_next;
                            rdata_hi_q   <= '0;
                            flags_q[3:1] <= {sh_next[DWIDTH-1], sh_next == '0, sh_out};
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign rdata_hi = rdata_hi_q;
    assign flags_o  = flags_q;

endmodule
